// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIGIT_W    = 3;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Index of the most-significant nonzero nibble; 0 when the word is zero.
    function automatic logic [DIGIT_W-1:0] top_digit(input logic [31:0] v);
        top_digit = '0;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] != 4'h0) top_digit = DIGIT_W'(i);
        end
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low seven-segment code, bit order {g,f,e,d,c,b,a}.
module hex_to_seg7 (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (nibble_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit seven-segment scanner with ghost blanking and tear-free frame updates.
// Define SEG_LZ_BLANK_EN to suppress leading zero digits (frame timing is unchanged).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned ON_CYC    = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        value_valid,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        update_pending,
    output logic        frame_done
);

    localparam int unsigned CNT_MAX = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    scan_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic [31:0]        shown_q, shown_d;
    logic [31:0]        pend_val_q, pend_val_d;
    logic               pend_q, pend_d;
    logic [7:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               frame_done_q, frame_done_d;
    logic [6:0]         dec_seg;
    logic               blank_last, drive_last;

    assign blank_last = (cnt_q == CNT_W'(BLANK_CYC - 1));
    assign drive_last = (cnt_q == CNT_W'(ON_CYC - 1));

    hex_to_seg7 u_dec (
        .nibble_i (shown_q[{digit_q, 2'b00} +: 4]),
        .seg_o    (dec_seg)
    );

`ifdef SEG_LZ_BLANK_EN
    logic [DIGIT_W-1:0] lz_top;
    assign lz_top = top_digit(shown_q);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            digit_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
        end
    end

    // Phase sequencing; the counter clears on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        digit_d = digit_q;
        unique case (state_q)
            BLANK: begin
                if (blank_last) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (drive_last) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    digit_d = digit_q + DIGIT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        an_d         = AN_OFF;
        seg_d        = SEG_OFF;
        frame_done_d = 1'b0;
        if (state_q == DRIVE) begin
            an_d         = ~(8'b1 << digit_q);
            seg_d        = dec_seg;
            frame_done_d = drive_last && (digit_q == DIGIT_W'(NUM_DIGITS - 1));
`ifdef SEG_LZ_BLANK_EN
            if (digit_q > lz_top) begin
                an_d  = AN_OFF;
                seg_d = SEG_OFF;
            end
`endif
        end
    end

    // shown only moves on the visible frame_done cycle, while the scan is blanking digit 0.
    always_comb begin
        shown_d    = shown_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        if (frame_done_q) begin
            if (value_valid) begin
                shown_d = value;
            end else if (pend_q) begin
                shown_d = pend_val_q;
            end
            pend_d = 1'b0;
        end else if (value_valid) begin
            pend_val_d = value;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
            shown_q      <= '0;
            pend_val_q   <= '0;
            pend_q       <= 1'b0;
        end else begin
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            shown_q      <= shown_d;
            pend_val_q   <= pend_val_d;
            pend_q       <= pend_d;
        end
    end

    assign an             = an_q;
    assign seg            = seg_q;
    assign frame_done     = frame_done_q;
    assign update_pending = pend_q;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The module SHALL have one clock, clk, and reset, which is asynchronous and active-high.
REQ-002 Parameter ON_CYC, default 1000, SHALL set the clk cycles each digit is driven; legal values are 1 or more.
REQ-003 Parameter BLANK_CYC, default 16, SHALL set the clk cycles of all-off ghost blanking before each digit; legal values are 1 or more.
REQ-004 clk input 1: rising-edge clock for the whole block.
REQ-005 reset input 1: asynchronous, active-high reset.
REQ-006 value input 32: hex word to display, for example the processor seg_display bus.
REQ-007 value_valid input 1: one-cycle load strobe for value.
REQ-008 an output 8: active-low digit anodes; an[i] selects nibble value[4i+3:4i].
REQ-009 seg output 7: active-low cathodes, bit order {g,f,e,d,c,b,a}.
REQ-010 update_pending output 1: high while a loaded value waits for the frame boundary.
REQ-011 frame_done output 1: one-cycle pulse on the last cycle of digit 7's DRIVE phase.

Function
REQ-012 The module SHALL scan digits 0 to 7, then wrap to 0; each digit slot SHALL be a BLANK phase of BLANK_CYC cycles followed by a DRIVE phase of ON_CYC cycles; a frame SHALL be 8*(BLANK_CYC+ON_CYC) cycles.
REQ-013 The FSM SHALL have two states: BLANK goes to DRIVE when the phase counter reaches BLANK_CYC-1; DRIVE goes to BLANK when the counter reaches ON_CYC-1, advancing the digit index, and the counter SHALL clear on every transition.
REQ-014 In BLANK, an SHALL be 8'hFF and seg SHALL be 7'h7F.
REQ-015 In DRIVE, an SHALL be ~(8'b1 << digit) and seg SHALL be the hex decode of the shown nibble.
REQ-016 All outputs SHALL be registered, with one state-to-output cycle of latency that is applied uniformly.
REQ-017 The hex decode SHALL be 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 B=03 C=46 D=21 E=06 F=0E (hex, 7-bit).
REQ-018 On value_valid, value SHALL load into a pending register and set the pending flag; a later strobe in the same frame SHALL overwrite the earlier one.
REQ-019 The displayed (shown) register SHALL change only on the frame_done cycle, so that a frame never tears.
REQ-020 On the frame_done cycle, if value_valid is high, shown SHALL take value directly; otherwise, if the pending flag is set, shown SHALL take the pending register.
REQ-021 On the frame_done cycle the pending flag SHALL clear in both cases of REQ-020.
REQ-022 update_pending SHALL equal the pending flag.
REQ-023 value_valid SHALL be accepted on every cycle, and no strobe SHALL be dropped except by a later overwrite.

Reset
REQ-024 While reset is high, an SHALL be 8'hFF, seg 7'h7F, frame_done 0, update_pending 0, shown 0, pending 0, digit 0, state BLANK and counter 0, all taking effect immediately without waiting for clk.
REQ-025 A reset asserted mid-frame SHALL abandon the frame and discard any pending value.
REQ-026 After reset deasserts, the first DRIVE phase, on digit 0, SHALL begin BLANK_CYC cycles later.

Configuration
REQ-027 When macro SEG_LZ_BLANK_EN is defined, leading zero digits SHALL be suppressed: every digit above the most-significant nonzero nibble of shown SHALL keep its anode high during DRIVE, and digit 0 SHALL always be driven.
REQ-028 When SEG_LZ_BLANK_EN is undefined, all 8 digits SHALL always be driven.
REQ-029 Frame timing SHALL be identical with and without SEG_LZ_BLANK_EN.

Structure
REQ-030 Package seg_pkg SHALL hold the NUM_DIGITS=8 constant, the scan_state_t enum (BLANK, DRIVE), and the blank-pattern constants AN_OFF=8'hFF and SEG_OFF=7'h7F.
REQ-031 A combinational sub-module hex_to_seg7 SHALL implement the REQ-017 decode, taking a 4-bit nibble in and producing the 7-bit seg code.

Verification
REQ-032 The bench SHALL run with ON_CYC=4 and BLANK_CYC=2, giving a 6-cycle slot and a 48-cycle frame.
REQ-033 Reset scenario: assert reset mid-DRIVE -> an=FF and seg=7F with no clk edge; release -> digit 0 is driven starting 2 cycles later.
REQ-034 Coherent-load scenario: strobe 32'h89ABCDEF at digit 3 -> update_pending=1 and the current frame keeps its old digits; next frame shows digit 0 as seg=0E with an=FE, and digit 7 as seg=00 with an=7F.
REQ-035 Overwrite scenario: strobe 32'h11111111, then 32'h22222222 in the same frame -> the next frame shows seg=24 on all digits, and 0x1 never appears.
REQ-036 Boundary scenario: strobe 32'h00000005 on the frame_done cycle while pending holds 32'h3 -> the next frame shows digit 0 as seg=12 and update_pending=0.
REQ-037 Macro scenario: with SEG_LZ_BLANK_EN defined, value 32'h00000A00 -> digits 0 to 2 are driven (digit 2 as seg=08) and an[7:3] stays high; value 0 -> only digit 0 is driven, as seg=40.
